// File: rtl/ahbl_cmd_master_if.sv
// Command-side handshake plus AHB-Lite master bus for ahbl_cmd_master.
// The master modport is the block's view; the slave modport is the requester/bus-slave side.
interface ahbl_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [15:0] xfer_cnt;
  logic [15:0] err_cnt;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  HREADY, HRESP, HRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output HADDR, HWRITE, HSIZE, HTRANS, HBURST, HPROT, HWDATA,
    output xfer_cnt, err_cnt
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output HREADY, HRESP, HRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  HADDR, HWRITE, HSIZE, HTRANS, HBURST, HPROT, HWDATA,
    input  xfer_cnt, err_cnt
  );
endinterface

// File: rtl/ahbl_cmd_master.sv
// Single-outstanding AHB-Lite command master: address phase straight from cmd_*,
// one data-phase register, one registered response per accepted command.
module ahbl_cmd_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input logic               HCLK,
  input logic               HRESETn,
  ahbl_cmd_master_if.master bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic        dp_valid_q, dp_valid_d;
  logic        dp_local_q, dp_local_d;
  logic        dp_write_q, dp_write_d;
  logic [31:0] dp_wdata_q, dp_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [15:0] xfer_cnt_q, xfer_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic legal_s;
  logic bus_err_s;
  logic ready_s;
  logic accept_s;
  logic done_s;
  logic done_err_s;

  // Size/alignment legality of the presented command.
  always_comb begin
    legal_s = 1'b0;
    case (bus.cmd_size)
      3'd0:    legal_s = 1'b1;
      3'd1:    legal_s = ~bus.cmd_addr[0];
      3'd2:    legal_s = (bus.cmd_addr[1:0] == 2'b00);
      default: legal_s = 1'b0;
    endcase
  end

  // A bus error in progress blocks both acceptance and a new NONSEQ.
  assign bus_err_s  = dp_valid_q & ~dp_local_q & bus.HRESP;
  assign ready_s    = HRESETn & bus.HREADY & ~bus_err_s;
  assign accept_s   = bus.cmd_valid & ready_s;
  assign done_s     = dp_valid_q & bus.HREADY;
  assign done_err_s = dp_local_q | bus.HRESP;

  assign bus.cmd_ready = ready_s;
  assign bus.HTRANS    = (HRESETn & bus.cmd_valid & legal_s & ~bus_err_s) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = bus.cmd_addr;
  assign bus.HWRITE    = bus.cmd_write;
  assign bus.HSIZE     = bus.cmd_size;
  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HWDATA    = (dp_valid_q & dp_write_q) ? dp_wdata_q : 32'h0000_0000;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.xfer_cnt  = xfer_cnt_q;
  assign bus.err_cnt   = err_cnt_q;

  // Next-state for the data-phase register, response and counters.
  always_comb begin
    dp_valid_d  = dp_valid_q;
    dp_local_d  = dp_local_q;
    dp_write_d  = dp_write_q;
    dp_wdata_d  = dp_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0000_0000;
    xfer_cnt_d  = xfer_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (accept_s) begin
      dp_valid_d = 1'b1;
      dp_local_d = ~legal_s;
      dp_write_d = bus.cmd_write;
      dp_wdata_d = bus.cmd_wdata;
    end else if (bus.HREADY) begin
      dp_valid_d = 1'b0;
    end else begin
      dp_valid_d = dp_valid_q;
    end
    if (done_s) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = done_err_s;
      rsp_rdata_d = (~done_err_s & ~dp_write_q) ? bus.HRDATA : 32'h0000_0000;
      if (done_err_s) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end else begin
        xfer_cnt_d = xfer_cnt_q + 16'd1;
      end
    end else begin
      rsp_valid_d = 1'b0;
    end
  end

  // State update with synchronous active-low reset; an in-flight phase is dropped silently.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_valid_q  <= 1'b0;
      dp_local_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      xfer_cnt_q  <= 16'h0000;
      err_cnt_q   <= 16'h0000;
    end else begin
      dp_valid_q  <= dp_valid_d;
      dp_local_q  <= dp_local_d;
      dp_write_q  <= dp_write_d;
      dp_wdata_q  <= dp_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      xfer_cnt_q  <= xfer_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_ahbl_cmd_master.sv
// Cycle-vector bench for ahbl_cmd_master: a table of per-cycle stimulus with
// hand-computed expectations, plus hand-written error and reset sequences.
module tb_ahbl_cmd_master;

  localparam logic [1:0]  IDL = 2'b00;
  localparam logic [1:0]  NS  = 2'b10;
  localparam logic [31:0] H   = 32'hCAFE_F00D;

  typedef struct {
    logic        rstn;
    logic        cv;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wd;
    logic        hrdy;
    logic        hresp;
    logic [31:0] hrd;
    logic        e_rdy;
    logic [1:0]  e_tr;
    logic [31:0] e_hwd;
    logic        e_rv;
    logic        e_re;
    logic [31:0] e_rd;
    logic [15:0] e_xc;
    logic [15:0] e_ec;
  } vec_t;

  logic HCLK;
  logic HRESETn;
  int   n_chk;
  int   n_fail;
  vec_t vecs[$];

  ahbl_cmd_master_if bus ();

  ahbl_cmd_master #(.HPROT_VAL(4'b0011)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.master)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  function automatic vec_t mk(input logic rstn, cv, wr, input logic [31:0] addr,
                              input logic [2:0] size, input logic [31:0] wd,
                              input logic hrdy, hresp, input logic [31:0] hrd,
                              input logic rdy, input logic [1:0] tr, input logic [31:0] hwd,
                              input logic rv, re, input logic [31:0] rd,
                              input logic [15:0] xc, ec);
    vec_t v;
    v.rstn = rstn; v.cv = cv; v.wr = wr; v.addr = addr; v.size = size; v.wd = wd;
    v.hrdy = hrdy; v.hresp = hresp; v.hrd = hrd;
    v.e_rdy = rdy; v.e_tr = tr; v.e_hwd = hwd; v.e_rv = rv; v.e_re = re; v.e_rd = rd;
    v.e_xc = xc; v.e_ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    HRESETn       = v.rstn;
    bus.cmd_valid = v.cv;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_size  = v.size;
    bus.cmd_wdata = v.wd;
    bus.HREADY    = v.hrdy;
    bus.HRESP     = v.hresp;
    bus.HRDATA    = v.hrd;
  endtask

  // One cycle: drive just after the rising edge, compare on the falling edge.
  task automatic step(input string tag, input vec_t v);
    @(posedge HCLK);
    #1;
    drive(v);
    @(negedge HCLK);
    chk({tag, ".ready"}, {31'd0, bus.cmd_ready}, {31'd0, v.e_rdy});
    chk({tag, ".htrans"}, {30'd0, bus.HTRANS}, {30'd0, v.e_tr});
    chk({tag, ".hwdata"}, bus.HWDATA, v.e_hwd);
    chk({tag, ".rsp_valid"}, {31'd0, bus.rsp_valid}, {31'd0, v.e_rv});
    chk({tag, ".rsp_err"}, {31'd0, bus.rsp_err}, {31'd0, v.e_re});
    chk({tag, ".rsp_rdata"}, bus.rsp_rdata, v.e_rd);
    chk({tag, ".xfer_cnt"}, {16'd0, bus.xfer_cnt}, {16'd0, v.e_xc});
    chk({tag, ".err_cnt"}, {16'd0, bus.err_cnt}, {16'd0, v.e_ec});
    if (v.cv) begin
      chk({tag, ".haddr"}, bus.HADDR, v.addr);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    drive(mk(1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0, H,
             1'b0, IDL, 32'h0, 1'b0, 1'b0, 32'h0, 16'd0, 16'd0));
    repeat (2) @(posedge HCLK);

    // rstn cv wr addr size wd | hrdy hresp hrdata | rdy htrans hwdata | rv re rdata | xc ec
    // reset state, then zero-wait read
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h2000_0004, 3'd2, 32'h0, 1'b1, 1'b0, H,            1'b0, IDL, 32'h0,  1'b0, 1'b0, 32'h0,         16'd0, 16'd0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h2000_0004, 3'd2, 32'h0, 1'b1, 1'b0, H,            1'b1, NS,  32'h0,  1'b0, 1'b0, 32'h0,         16'd0, 16'd0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,         3'd0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, IDL, 32'h0,  1'b0, 1'b0, 32'h0,         16'd0, 16'd0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,         3'd0, 32'h0, 1'b1, 1'b0, H,            1'b1, IDL, 32'h0,  1'b1, 1'b0, 32'hDEADBEEF,  16'd1, 16'd0));
    // three back-to-back writes
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h0,   3'd2, 32'h11, 1'b1, 1'b0, H, 1'b1, NS,  32'h0,  1'b0, 1'b0, 32'h0, 16'd1, 16'd0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h4,   3'd2, 32'h22, 1'b1, 1'b0, H, 1'b1, NS,  32'h11, 1'b0, 1'b0, 32'h0, 16'd1, 16'd0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h8,   3'd2, 32'h33, 1'b1, 1'b0, H, 1'b1, NS,  32'h22, 1'b1, 1'b0, 32'h0, 16'd2, 16'd0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0,  1'b1, 1'b0, H, 1'b1, IDL, 32'h33, 1'b1, 1'b0, 32'h0, 16'd3, 16'd0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0,  1'b1, 1'b0, H, 1'b1, IDL, 32'h0,  1'b1, 1'b0, 32'h0, 16'd4, 16'd0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0,  1'b1, 1'b0, H, 1'b1, IDL, 32'h0,  1'b0, 1'b0, 32'h0, 16'd4, 16'd0));
    // misaligned word, then oversize, then aligned halfword read
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h3,   3'd2, 32'h0,  1'b1, 1'b0, H, 1'b1, IDL, 32'h0,  1'b0, 1'b0, 32'h0, 16'd4, 16'd0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0,  1'b1, 1'b0, H, 1'b1, IDL, 32'h0,  1'b0, 1'b0, 32'h0, 16'd4, 16'd0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0,  1'b1, 1'b0, H, 1'b1, IDL, 32'h0,  1'b1, 1'b1, 32'h0, 16'd4, 16'd1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0,   3'd3, 32'h0,  1'b1, 1'b0, H, 1'b1, IDL, 32'h0,  1'b0, 1'b0, 32'h0, 16'd4, 16'd1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0,  1'b1, 1'b0, H, 1'b1, IDL, 32'h0,  1'b0, 1'b0, 32'h0, 16'd4, 16'd1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0,  1'b1, 1'b0, H, 1'b1, IDL, 32'h0,  1'b1, 1'b1, 32'h0, 16'd4, 16'd2));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h2,   3'd1, 32'h0,  1'b1, 1'b0, H, 1'b1, NS,  32'h0,  1'b0, 1'b0, 32'h0, 16'd4, 16'd2));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0,  1'b1, 1'b0, 32'h1234, 1'b1, IDL, 32'h0, 1'b0, 1'b0, 32'h0,    16'd4, 16'd2));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0,  1'b1, 1'b0, H, 1'b1, IDL, 32'h0,  1'b1, 1'b0, 32'h1234, 16'd5, 16'd2));
    // write with two wait states and a queued read
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h100, 3'd2, 32'hAA, 1'b1, 1'b0, H, 1'b1, NS,  32'h0,  1'b0, 1'b0, 32'h0, 16'd5, 16'd2));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h104, 3'd2, 32'h0,  1'b0, 1'b0, H, 1'b0, NS,  32'hAA, 1'b0, 1'b0, 32'h0, 16'd5, 16'd2));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h104, 3'd2, 32'h0,  1'b0, 1'b0, H, 1'b0, NS,  32'hAA, 1'b0, 1'b0, 32'h0, 16'd5, 16'd2));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h104, 3'd2, 32'h0,  1'b1, 1'b0, H, 1'b1, NS,  32'hAA, 1'b0, 1'b0, 32'h0, 16'd5, 16'd2));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0,  1'b1, 1'b0, 32'h5555AAAA, 1'b1, IDL, 32'h0, 1'b1, 1'b0, 32'h0,        16'd6, 16'd2));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0,  1'b1, 1'b0, H, 1'b1, IDL, 32'h0,  1'b1, 1'b0, 32'h5555AAAA, 16'd7, 16'd2));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0,  1'b1, 1'b0, H, 1'b1, IDL, 32'h0,  1'b0, 1'b0, 32'h0,        16'd7, 16'd2));

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("v%0d", i), vecs[i]);
    end
    chk("hprot", {28'd0, bus.HPROT}, 32'h3);
    chk("hburst", {29'd0, bus.HBURST}, 32'h0);

    // two-cycle ERROR on a read with a queued write
    step("err1", mk(1'b1, 1'b1, 1'b0, 32'h200, 3'd2, 32'h0,  1'b1, 1'b0, H, 1'b1, NS,  32'h0,  1'b0, 1'b0, 32'h0, 16'd7, 16'd2));
    step("err2", mk(1'b1, 1'b1, 1'b1, 32'h204, 3'd2, 32'h77, 1'b0, 1'b1, H, 1'b0, IDL, 32'h0,  1'b0, 1'b0, 32'h0, 16'd7, 16'd2));
    step("err3", mk(1'b1, 1'b1, 1'b1, 32'h204, 3'd2, 32'h77, 1'b1, 1'b1, H, 1'b0, IDL, 32'h0,  1'b0, 1'b0, 32'h0, 16'd7, 16'd2));
    step("err4", mk(1'b1, 1'b1, 1'b1, 32'h204, 3'd2, 32'h77, 1'b1, 1'b0, H, 1'b1, NS,  32'h0,  1'b1, 1'b1, 32'h0, 16'd7, 16'd3));
    step("err5", mk(1'b1, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0,  1'b1, 1'b0, H, 1'b1, IDL, 32'h77, 1'b0, 1'b0, 32'h0, 16'd7, 16'd3));
    step("err6", mk(1'b1, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0,  1'b1, 1'b0, H, 1'b1, IDL, 32'h0,  1'b1, 1'b0, 32'h0, 16'd8, 16'd3));

    // reset during a wait-stated read, then acceptance in the first cycle out of reset
    step("rst1", mk(1'b1, 1'b1, 1'b0, 32'h300, 3'd2, 32'h0, 1'b1, 1'b0, H, 1'b1, NS,  32'h0, 1'b0, 1'b0, 32'h0,  16'd8, 16'd3));
    step("rst2", mk(1'b1, 1'b1, 1'b0, 32'h304, 3'd2, 32'h0, 1'b0, 1'b0, H, 1'b0, NS,  32'h0, 1'b0, 1'b0, 32'h0,  16'd8, 16'd3));
    step("rst3", mk(1'b0, 1'b1, 1'b0, 32'h304, 3'd2, 32'h0, 1'b0, 1'b0, H, 1'b0, IDL, 32'h0, 1'b0, 1'b0, 32'h0,  16'd8, 16'd3));
    step("rst4", mk(1'b0, 1'b1, 1'b0, 32'h304, 3'd2, 32'h0, 1'b1, 1'b0, H, 1'b0, IDL, 32'h0, 1'b0, 1'b0, 32'h0,  16'd0, 16'd0));
    step("rst5", mk(1'b1, 1'b1, 1'b0, 32'h304, 3'd2, 32'h0, 1'b1, 1'b0, H, 1'b1, NS,  32'h0, 1'b0, 1'b0, 32'h0,  16'd0, 16'd0));
    step("rst6", mk(1'b1, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0, 1'b1, 1'b0, 32'h99, 1'b1, IDL, 32'h0, 1'b0, 1'b0, 32'h0,  16'd0, 16'd0));
    step("rst7", mk(1'b1, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0, 1'b1, 1'b0, H, 1'b1, IDL, 32'h0, 1'b1, 1'b0, 32'h99, 16'd1, 16'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahbl_cmd_master.md
AHBL_CMD_MASTER -- requirements
Module: ahbl_cmd_master

Interface
REQ-001 Parameter: HPROT_VAL, 4'b0011, constant value driven on HPROT.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 HCLK  in  1  bus clock; all state changes on its rising edge.
REQ-004 HRESETn  in  1  synchronous, active-low reset.
REQ-005 cmd_valid  in  1  command present.
REQ-006 cmd_ready  out  1  command accepted this cycle when cmd_valid=1.
REQ-007 cmd_write  in  1  1=write, 0=read.
REQ-008 cmd_addr  in  32  byte address.
REQ-009 cmd_size  in  3  AHB HSIZE encoding.
REQ-010 cmd_wdata  in  32  write data, already placed on the correct byte lanes.
REQ-011 rsp_valid  out  1  one-cycle response pulse.
REQ-012 rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-013 rsp_err  out  1  transfer ended in error.
REQ-014 HADDR/HWRITE/HSIZE  out  32/1/3  address-phase signals.
REQ-015 HTRANS  out  2  IDLE=2'b00 or NONSEQ=2'b10 only.
REQ-016 HBURST/HPROT  out  3/4  constant 3'b000 / HPROT_VAL.
REQ-017 HWDATA  out  32  data-phase write data.
REQ-018 HREADY/HRESP/HRDATA  in  1/1/32  slave-side response.
REQ-019 xfer_cnt/err_cnt  out  16/16  completed OKAY transfers / error responses.

Function
REQ-020 Operation is a two-stage pipeline: the address phase is driven combinationally from cmd_*; the data-phase register set holds dp_valid, dp_local, dp_write, dp_wdata.
REQ-021 A command is legal when cmd_size<=2 and cmd_addr is aligned: size 1 needs addr[0]=0; size 2 needs addr[1:0]=0.
REQ-022 Bus error condition busErr = dp_valid & !dp_local & HRESP.
REQ-023 cmd_ready = HRESETn & HREADY & !busErr.
REQ-024 HTRANS = NONSEQ iff HRESETn & cmd_valid & legal & !busErr; otherwise IDLE. HADDR, HWRITE and HSIZE follow cmd_* at all times.
REQ-025 On handshake (cmd_valid & cmd_ready), the data-phase register loads dp_valid=1, dp_local=!legal, dp_write, and dp_wdata from the command.
REQ-026 On HREADY=1 with no new handshake, dp_valid clears; while HREADY=0 the data-phase register holds.
REQ-027 HWDATA = dp_wdata while dp_valid & dp_write; otherwise 0.
REQ-028 A bus data phase completes on a cycle with HREADY=1; the next cycle the block drives rsp_valid=1, rsp_err=HRESP, and rsp_rdata=HRDATA when the transfer was an OKAY read, else 0.
REQ-029 A local (illegal) phase issues no bus transfer and completes on the same rule; the next cycle drives rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-030 The two-cycle AHB error (cycle 1: HRESP=1, HREADY=0; cycle 2: HRESP=1, HREADY=1) forces HTRANS=IDLE and cmd_ready=0 in both cycles. The pending command stays unaccepted and is issued afterwards.
REQ-031 Back-to-back: a new command is accepted in the same cycle the previous data phase completes; zero-wait-state throughput is one transfer per cycle.
REQ-032 Exactly one response per accepted command, in acceptance order; latency is acceptance + 1 + wait states + 1.
REQ-033 xfer_cnt increments on each OKAY completion; err_cnt increments on each bus or local error. Both wrap 16'hFFFF->0.
REQ-034 The requester holds cmd_* stable while cmd_valid=1 and cmd_ready=0; the block does not check this.

Reset
REQ-035 While HRESETn=0 at a rising edge, the block clears dp_valid, dp_local, dp_write, dp_wdata, rsp_valid, rsp_err, rsp_rdata, xfer_cnt and err_cnt.
REQ-036 While HRESETn=0, HTRANS=IDLE and cmd_ready=0 combinationally.
REQ-037 Reset mid-transfer discards any in-flight data phase without a response.
REQ-038 First acceptance is possible in the first cycle with HRESETn=1.

Verification
REQ-039 Zero-wait read: cmd addr 0x2000_0004, size 2; slave HRDATA=0xDEADBEEF -> HTRANS=NONSEQ one cycle; rsp_valid=1, rsp_rdata=0xDEADBEEF, rsp_err=0 two cycles after acceptance; xfer_cnt=1.
REQ-040 Three back-to-back writes 0x0, 0x4, 0x8 with data 0x11/0x22/0x33, HREADY=1 -> three consecutive NONSEQ cycles; HWDATA=0x11, 0x22, 0x33 one cycle lagged; three consecutive rsp_valid pulses.
REQ-041 Write with 2 wait states (HREADY=0 for 2 cycles) and a second command queued -> HADDR holds the second address; the second acceptance lands on the HREADY=1 cycle; responses arrive in order.
REQ-042 Two-cycle ERROR on a read with a queued command -> HTRANS=IDLE in both error cycles; rsp_err=1; err_cnt=1; queued command issued the cycle after.
REQ-043 Misaligned cmd addr 0x3, size 2 -> no NONSEQ; rsp_valid=1, rsp_err=1 two cycles later; err_cnt=1.
REQ-044 HRESETn=0 during a wait-stated data phase -> no rsp_valid; counters 0; HTRANS=IDLE until release.
